// File: rtl/ps2_device.sv
// Device-side PS/2 endpoint: generates the PS/2 clock, sends scan codes to the
// host and receives host commands, including the acknowledge pulse.
// Both lines are open-drain. The *_out pins are tied low, and *_oe = 1 pulls a line low.
module ps2_device #(
    parameter int CLK_HZ      = 51_800_000,
    parameter int PS2_HZ      = 12_500,
    parameter int IDLE_CYCLES = 2590
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_out,
    output logic       ps2_clk_oe,
    input  logic       ps2_data_in,
    output logic       ps2_data_out,
    output logic       ps2_data_oe,
    input  logic       scan_code_valid,
    input  logic [7:0] scan_code_byte,
    output logic       scan_code_ready,
    input  logic       command_ready,
    output logic       command_valid,
    output logic [7:0] command_byte,
    output logic       command_error,
    output logic [2:0] o_dbg_state
);

    localparam int HALF  = CLK_HZ / (2 * PS2_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_TARGET = IDLE_W'(IDLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX_BIT  = 3'd1,
        S_RX_WAIT = 3'd2,
        S_RX_BIT  = 3'd3,
        S_RX_ACK  = 3'd4,
        S_RX_HOLD = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_clk_s1, r_clk_s2;
    logic               r_dat_s1, r_dat_s2;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_phase;      // 0 = first half of a bit/pulse, 1 = second half
    logic [3:0]         r_bit;
    logic [7:0]         r_tx_byte;
    logic               r_pending;
    logic [9:0]         r_rx_shift;   // after 10 shifts: [7:0] data, [8] parity, [9] stop
    logic               r_clk_oe, r_data_oe;
    logic               r_cmd_valid;
    logic [7:0]         r_cmd_byte;
    logic               r_cmd_err;

    logic               w_bus_idle, w_host_req, w_idle_ok, w_half_done, w_accept;
    logic [15:0]        w_tx_frame;
    logic [3:0]         w_next_bit;

    assign w_bus_idle  = r_clk_s2 & r_dat_s2;
    assign w_host_req  = r_clk_s2 & ~r_dat_s2;
    assign w_idle_ok   = (r_idle_cnt >= IDLE_TARGET);
    assign w_half_done = (r_cnt == HALF_LAST);
    assign w_accept    = scan_code_valid & scan_code_ready;
    assign w_next_bit  = r_bit + 4'd1;
    // Frame is sent bit 0 first: start, d0..d7, odd parity, stop. The padding keeps 4-bit indexing in range.
    assign w_tx_frame  = {5'b11111, 1'b1, ~^r_tx_byte, r_tx_byte, 1'b0};

    assign ps2_clk_out     = 1'b0;
    assign ps2_data_out    = 1'b0;
    assign ps2_clk_oe      = r_clk_oe;
    assign ps2_data_oe     = r_data_oe;
    assign scan_code_ready = (r_state == S_IDLE) & ~r_pending & ~reset;
    assign command_valid   = r_cmd_valid;
    assign command_byte    = r_cmd_byte;
    assign command_error   = r_cmd_err;
    assign o_dbg_state     = r_state;

    // Two-flop synchronisers for the asynchronous line senses. An idle bus reads high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Count how long both lines have been high. The count saturates and clears on any low level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (w_bus_idle) begin
            if (r_idle_cnt != IDLE_TARGET) r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end else begin
            r_idle_cnt <= '0;
        end
    end

    // Link FSM: handles scan-code accept, TX framing with host-inhibit abort, RX framing with ack, and the command handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
            r_bit       <= '0;
            r_tx_byte   <= '0;
            r_pending   <= 1'b0;
            r_rx_shift  <= '0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_byte  <= '0;
            r_cmd_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tx_byte <= scan_code_byte;
                r_pending <= 1'b1;
            end
            if (r_cmd_valid && command_ready) r_cmd_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_cnt     <= '0;
                    r_phase   <= 1'b0;
                    r_bit     <= '0;
                    if (w_host_req) begin
                        // A host request waits here until the previous command has been consumed.
                        if (!r_cmd_valid) r_state <= S_RX_WAIT;
                    end else if (r_pending && w_idle_ok) begin
                        r_state   <= S_TX_BIT;
                        r_data_oe <= ~w_tx_frame[0];
                    end
                end
                S_TX_BIT: begin
                    if (!w_half_done) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            if (!r_clk_s2) begin
                                // The host is holding the clock low. Abort; the byte stays pending and is resent from the start.
                                r_clk_oe  <= 1'b0;
                                r_data_oe <= 1'b0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_phase  <= 1'b1;
                                r_clk_oe <= 1'b1;
                            end
                        end else begin
                            r_clk_oe <= 1'b0;
                            r_phase  <= 1'b0;
                            if (r_bit == 4'd10) begin
                                r_data_oe <= 1'b0;
                                r_pending <= 1'b0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_bit     <= w_next_bit;
                                r_data_oe <= ~w_tx_frame[w_next_bit];
                            end
                        end
                    end
                end
                S_RX_WAIT: begin
                    if (!w_half_done) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt    <= '0;
                        r_phase  <= 1'b0;
                        r_bit    <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= S_RX_BIT;
                    end
                end
                S_RX_BIT: begin
                    if (!w_half_done) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            // Rising clock edge: sample the host's data bit (LSB first).
                            r_clk_oe   <= 1'b0;
                            r_phase    <= 1'b1;
                            r_rx_shift <= {r_dat_s2, r_rx_shift[9:1]};
                        end else if (r_bit == 4'd9) begin
                            r_phase <= 1'b0;
                            if (r_rx_shift[9]) begin
                                r_clk_oe  <= 1'b1;
                                r_data_oe <= 1'b1;
                                r_state   <= S_RX_ACK;
                            end else begin
                                r_state <= S_RX_HOLD;
                            end
                        end else begin
                            r_bit    <= w_next_bit;
                            r_phase  <= 1'b0;
                            r_clk_oe <= 1'b1;
                        end
                    end
                end
                S_RX_ACK: begin
                    if (!w_half_done) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            r_clk_oe <= 1'b0;
                            r_phase  <= 1'b1;
                        end else begin
                            r_data_oe <= 1'b0;
                            r_phase   <= 1'b0;
                            r_state   <= S_RX_HOLD;
                        end
                    end
                end
                S_RX_HOLD: begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_byte  <= r_rx_shift[7:0];
                    r_cmd_err   <= ~(^r_rx_shift[8:0]) | ~r_rx_shift[9];
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device.sv
// Self-checking bench for ps2_device. It models the host side of the open-drain link
// and checks the results against a frame-level reference model.
`timescale 1ns/1ps
module tb_ps2_device;

    localparam int CLK_HZ = 2000;
    localparam int PS2_HZ = 100;
    localparam int HALF   = CLK_HZ / (2 * PS2_HZ);
    localparam int IDLE   = 25;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- host-side line model ----------------
    logic host_clk_low = 1'b0;
    logic host_data_low = 1'b0;
    logic clk_line, data_line;

    logic       ps2_clk_out, ps2_clk_oe, ps2_data_out, ps2_data_oe;
    logic       scan_code_valid = 1'b0;
    logic [7:0] scan_code_byte = 8'h00;
    logic       scan_code_ready;
    logic       command_ready = 1'b0;
    logic       command_valid;
    logic [7:0] command_byte;
    logic       command_error;
    logic [2:0] dbg_state;

    assign clk_line  = ~(ps2_clk_oe | host_clk_low);
    assign data_line = ~(ps2_data_oe | host_data_low);

    ps2_device #(.CLK_HZ(CLK_HZ), .PS2_HZ(PS2_HZ), .IDLE_CYCLES(IDLE)) dut (
        .clk(clk), .reset(reset),
        .ps2_clk_in(clk_line), .ps2_clk_out(ps2_clk_out), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_in(data_line), .ps2_data_out(ps2_data_out), .ps2_data_oe(ps2_data_oe),
        .scan_code_valid(scan_code_valid), .scan_code_byte(scan_code_byte),
        .scan_code_ready(scan_code_ready),
        .command_ready(command_ready), .command_valid(command_valid),
        .command_byte(command_byte), .command_error(command_error),
        .o_dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic odd_parity_bit(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Frame as seen on the wire; bit 0 is sent first.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = b[i];
        f[9]  = odd_parity_bit(b);
        f[10] = 1'b1;
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic offer(input logic [7:0] b, output logic ok);
        int cyc;
        cyc = 0;
        @(negedge clk);
        scan_code_byte  = b;
        scan_code_valid = 1'b1;
        while (!scan_code_ready && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        ok = scan_code_ready;
        @(negedge clk);
        scan_code_valid = 1'b0;
    endtask

    // Host side of a device transmission: samples data at each clock falling edge.
    task automatic capture_frame(input int max_falls, input int budget, output logic [10:0] bits,
                                 output int nfalls, output int bad_periods, output int ready_seen,
                                 output int first_at);
        int cyc, last;
        logic prev;
        cyc = 0; last = 0; prev = clk_line;
        bits = '0; nfalls = 0; bad_periods = 0; ready_seen = 0; first_at = -1;
        while (nfalls < max_falls && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (scan_code_ready) ready_seen++;
            if (prev && !clk_line) begin
                bits[nfalls] = data_line;
                if (nfalls == 0) first_at = cyc;
                else if (cyc - last != 2 * HALF) bad_periods++;
                last = cyc;
                nfalls++;
            end
            prev = clk_line;
        end
    endtask

    task automatic host_request();
        host_clk_low = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        host_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        host_clk_low = 1'b0;
    endtask

    // Host sends the data bits on the device clock and records the ack seen at the 11th falling edge.
    task automatic host_shift(input logic [7:0] b, input logic bad_par, output logic ack, output int nfalls);
        logic [9:0] bits;
        logic prev;
        int cyc;
        bits[7:0] = b;
        bits[8]   = odd_parity_bit(b) ^ bad_par;
        bits[9]   = 1'b1;
        prev = clk_line; cyc = 0; ack = 1'b0; nfalls = 0;
        while (nfalls < 11 && cyc < 40 * HALF) begin
            @(negedge clk);
            cyc++;
            if (prev && !clk_line) begin
                nfalls++;
                if (nfalls <= 10) host_data_low = ~bits[nfalls - 1];
                else ack = ~data_line;
            end
            prev = clk_line;
        end
        host_data_low = 1'b0;
        cyc = 0;
        while (!clk_line && cyc < 4 * HALF) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_cmd(output logic got);
        int cyc;
        cyc = 0;
        while (!command_valid && cyc < 4 * HALF) begin
            @(negedge clk);
            cyc++;
        end
        got = command_valid;
    endtask

    task automatic consume();
        @(negedge clk);
        command_ready = 1'b1;
        @(negedge clk);
        command_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
        n_checks++; if (scan_code_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", scan_code_ready); end
        n_checks++; if ({command_valid, command_byte, command_error} !== 10'h0) begin n_fail++; $display("FAIL reset_cmd: got %b/%h/%b want 0/00/0", command_valid, command_byte, command_error); end
        n_checks++; if ({ps2_clk_out, ps2_data_out} !== 2'b00) begin n_fail++; $display("FAIL reset_out_pins: got %b want 00", {ps2_clk_out, ps2_data_out}); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (scan_code_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", scan_code_ready); end
        n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL post_reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_tx_1c();
        logic ok;
        logic [10:0] bits;
        int nf, badp, rdy, first;
        repeat (2 * IDLE) @(negedge clk);
        offer(8'h1C, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tx1c_accept: got %b want 1", ok); end
        n_checks++; if (scan_code_ready !== 1'b0) begin n_fail++; $display("FAIL tx1c_ready_after_accept: got %b want 0", scan_code_ready); end
        capture_frame(11, 60 * HALF, bits, nf, badp, rdy, first);
        n_checks++; if (nf !== 11) begin n_fail++; $display("FAIL tx1c_clock_count: got %0d want 11", nf); end
        n_checks++; if (bits !== 11'b10000111000) begin n_fail++; $display("FAIL tx1c_bits_const: got %b want 10000111000", bits); end
        n_checks++; if (bits !== model_frame(8'h1C)) begin n_fail++; $display("FAIL tx1c_bits_model: got %b want %b", bits, model_frame(8'h1C)); end
        n_checks++; if (badp !== 0) begin n_fail++; $display("FAIL tx1c_period: got %0d bad periods want 0", badp); end
        n_checks++; if (rdy !== 0) begin n_fail++; $display("FAIL tx1c_ready_during: got %0d ready cycles want 0", rdy); end
        n_checks++; if (first < HALF || first > HALF + 3) begin n_fail++; $display("FAIL tx1c_first_edge: got %0d want %0d..%0d", first, HALF, HALF + 3); end
        repeat (2 * HALF) @(negedge clk);
        n_checks++; if ({ps2_clk_oe, ps2_data_oe, scan_code_ready} !== 3'b001) begin n_fail++; $display("FAIL tx1c_release: got %b want 001", {ps2_clk_oe, ps2_data_oe, scan_code_ready}); end
    endtask

    task automatic test_rx(input logic [7:0] b, input logic bad, input string name);
        logic ack, got;
        int nf;
        host_request();
        host_shift(b, bad, ack, nf);
        n_checks++; if (nf !== 11) begin n_fail++; $display("FAIL %s_pulses: got %0d want 11", name, nf); end
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL %s_ack: got %b want 1", name, ack); end
        wait_cmd(got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b want 1", name, got); end
        n_checks++; if (command_byte !== b) begin n_fail++; $display("FAIL %s_byte: got %h want %h", name, command_byte, b); end
        n_checks++; if (command_error !== bad) begin n_fail++; $display("FAIL %s_error: got %b want %b", name, command_error, bad); end
        consume();
        n_checks++; if (command_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid_clear: got %b want 0", name, command_valid); end
        n_checks++; if (command_byte !== b) begin n_fail++; $display("FAIL %s_byte_held: got %h want %h", name, command_byte, b); end
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic test_inhibit_5a();
        logic ok;
        logic [10:0] bits;
        int nf, badp, rdy, first, cyc;
        repeat (2 * IDLE) @(negedge clk);
        offer(8'h5A, ok);
        capture_frame(4, 30 * HALF, bits, nf, badp, rdy, first);
        cyc = 0;
        while (!clk_line && cyc < 2 * HALF) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
        host_clk_low = 1'b1;
        repeat (HALF + 4) @(negedge clk);
        n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fail++; $display("FAIL inhibit_release: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        repeat (3 * HALF) @(negedge clk);
        n_checks++; if ({ps2_clk_oe, scan_code_ready} !== 2'b00) begin n_fail++; $display("FAIL inhibit_hold_pending: got %b want 00", {ps2_clk_oe, scan_code_ready}); end
        host_clk_low = 1'b0;
        capture_frame(11, 80 * HALF, bits, nf, badp, rdy, first);
        n_checks++; if (bits !== model_frame(8'h5A) || nf !== 11) begin n_fail++; $display("FAIL inhibit_resend: got %b (%0d clocks) want %b", bits, nf, model_frame(8'h5A)); end
        n_checks++; if (first < IDLE + HALF || first > IDLE + HALF + 6) begin n_fail++; $display("FAIL inhibit_idle_gap: got %0d want %0d..%0d", first, IDLE + HALF, IDLE + HALF + 6); end
        repeat (2 * HALF) @(negedge clk);
        n_checks++; if (scan_code_ready !== 1'b1) begin n_fail++; $display("FAIL inhibit_done_ready: got %b want 1", scan_code_ready); end
    endtask

    task automatic test_backpressure();
        logic ack, got, bad;
        logic [7:0] b2;
        int nf, n_oe;
        host_request();
        host_shift(8'hF4, 1'b0, ack, nf);
        wait_cmd(got);
        n_checks++; if (got !== 1'b1 || command_byte !== 8'hF4) begin n_fail++; $display("FAIL bp_first: got %b/%h want 1/f4", got, command_byte); end
        host_request();
        n_oe = 0;
        repeat (8 * HALF) begin
            @(negedge clk);
            if (ps2_clk_oe) n_oe++;
        end
        n_checks++; if (n_oe !== 0) begin n_fail++; $display("FAIL bp_no_clocks: got %0d clock-low cycles want 0", n_oe); end
        n_checks++; if (command_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", command_valid); end
        b2  = 8'($urandom_range(0, 255));
        bad = 1'($urandom_range(0, 1));
        consume();
        n_checks++; if (command_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consume: got %b want 0", command_valid); end
        host_shift(b2, bad, ack, nf);
        wait_cmd(got);
        n_checks++; if (ack !== 1'b1 || got !== 1'b1) begin n_fail++; $display("FAIL bp_second_frame: got ack %b valid %b want 1 1", ack, got); end
        n_checks++; if (command_byte !== b2 || command_error !== bad) begin n_fail++; $display("FAIL bp_second_cmd: got %h/%b want %h/%b", command_byte, command_error, b2, bad); end
        consume();
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic test_random();
        logic ok, bad;
        logic [7:0] b;
        logic [10:0] bits, exp;
        int nf, badp, rdy, first;
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(model_frame(b));
            offer(b, ok);
            capture_frame(11, 80 * HALF, bits, nf, badp, rdy, first);
            exp = exp_q.pop_front();
            n_checks++; if (bits !== exp || nf !== 11 || badp !== 0) begin n_fail++; $display("FAIL rand_tx_%0d: got %b (%0d clocks, %0d bad) want %b", k, bits, nf, badp, exp); end
            repeat (2 * HALF) @(negedge clk);
            b   = 8'($urandom_range(0, 255));
            bad = 1'($urandom_range(0, 1));
            test_rx(b, bad, "rand_rx");
        end
    endtask

    task automatic test_reset_mid_tx();
        logic ok;
        logic [10:0] bits;
        int nf, badp, rdy, first, n_oe;
        repeat (2 * IDLE) @(negedge clk);
        offer(8'h77, ok);
        capture_frame(3, 30 * HALF, bits, nf, badp, rdy, first);
        n_checks++; if (ps2_clk_oe !== 1'b1) begin n_fail++; $display("FAIL midtx_pre_reset_clk: got %b want 1", ps2_clk_oe); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fail++; $display("FAIL midtx_reset_release: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        n_checks++; if (scan_code_ready !== 1'b0) begin n_fail++; $display("FAIL midtx_reset_ready: got %b want 0", scan_code_ready); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_oe = 0;
        repeat (2 * IDLE + 24 * HALF) begin
            @(negedge clk);
            if (ps2_clk_oe || ps2_data_oe) n_oe++;
        end
        n_checks++; if (n_oe !== 0) begin n_fail++; $display("FAIL midtx_no_resend: got %0d driven cycles want 0", n_oe); end
        n_checks++; if (scan_code_ready !== 1'b1) begin n_fail++; $display("FAIL midtx_ready_after: got %b want 1", scan_code_ready); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_tx_1c();
        test_rx(8'hED, 1'b0, "rx_ed");
        test_rx(8'hFF, 1'b1, "rx_ff_badpar");
        test_inhibit_5a();
        test_backpressure();
        test_random();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
